// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit packet scheduler.
// States are one-hot so each state decode is a single flop bit.
package tx_sched_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE = 4'b0001;
    localparam state_t ST_XFER = 4'b0010;
    localparam state_t ST_DROP = 4'b0100;
    localparam state_t ST_GAP  = 4'b1000;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Two-way round-robin pick: on a tie the source that did not go last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic rr_last);
        logic pick;
        pick = SRC0;
        if (req == 2'b11) begin
            pick = ~rr_last;
        end else if (req[1]) begin
            pick = SRC1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/tx_pkt_scheduler_rr_arb2.sv
// Registered two-input round-robin arbiter. The grant index only moves
// when load is asserted, so it holds the last winner between packets.
module rr_arb2
    import tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       load,
    output logic       gnt
);

    logic gnt_q;

    // Capture the round-robin winner whenever the owner asks for a new decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= SRC0;
        end else if (load) begin
            gnt_q <= rr_pick(req, rr_last);
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/tx_pkt_scheduler.sv
// Packet scheduler sharing one packetizer AXIS input between two sources.
// A whole packet is granted at a time, sources alternate round-robin, an
// idle gap follows each packet and over-long packets are cut at MAX_LEN.
module tx_pkt_scheduler
    import tx_sched_pkg::*;
#(
    parameter int BYTES      = 1,
    parameter int MAX_LEN    = 1024,
    parameter int GAP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTES*8-1:0] s0_tdata,
    input  logic               s0_tvalid,
    output logic               s0_tready,
    input  logic               s0_tlast,
    input  logic               s0_tuser,
    input  logic [BYTES*8-1:0] s1_tdata,
    input  logic               s1_tvalid,
    output logic               s1_tready,
    input  logic               s1_tlast,
    input  logic               s1_tuser,
    output logic [BYTES*8-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               m_tuser,
    output logic               grant,
    output logic               busy,
    output logic               trunc_err
);

    localparam int BEAT_W = $clog2(MAX_LEN) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no gap configured a finished packet goes straight back to IDLE.
    localparam state_t ST_END = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rr_last_q, rr_last_d;
    logic              trunc_q, trunc_d;
    logic              busy_q;

    logic [BYTES*8-1:0] src_tdata;
    logic               src_tvalid;
    logic               src_tlast;
    logic               src_tuser;
    logic               src_ready;
    logic               in_idle;
    logic               in_xfer;
    logic               in_drop;
    logic               last_slot;
    logic               m_hs;
    logic               drop_hs;
    logic               arb_load;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_xfer   = (state_q == ST_XFER);
    assign in_drop   = (state_q == ST_DROP);
    assign last_slot = (beat_q == BEAT_LAST);
    assign arb_load  = in_idle & (s0_tvalid | s1_tvalid);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({s1_tvalid, s0_tvalid}),
        .rr_last (rr_last_q),
        .load    (arb_load),
        .gnt     (grant)
    );

    // Select the granted source; everything downstream sees only this view.
    always_comb begin
        src_tdata  = s0_tdata;
        src_tvalid = s0_tvalid;
        src_tlast  = s0_tlast;
        src_tuser  = s0_tuser;
        if (grant == SRC1) begin
            src_tdata  = s1_tdata;
            src_tvalid = s1_tvalid;
            src_tlast  = s1_tlast;
            src_tuser  = s1_tuser;
        end
    end

    // Zero-latency forwarding: master side mirrors the granted source in XFER,
    // the source is drained unconditionally in DROP and held off otherwise.
    always_comb begin
        m_tdata   = src_tdata;
        m_tvalid  = in_xfer & src_tvalid;
        m_tlast   = in_xfer & (src_tlast | last_slot);
        m_tuser   = in_xfer & src_tuser;
        src_ready = (in_xfer & m_tready) | in_drop;
        s0_tready = src_ready & (grant == SRC0);
        s1_tready = src_ready & (grant == SRC1);
        m_hs      = in_xfer & src_tvalid & m_tready;
        drop_hs   = in_drop & src_tvalid;
    end

    // Next-state logic for the packet FSM, beat counter, gap timer and fairness bit.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        rr_last_d = rr_last_q;
        trunc_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_load) begin
                    state_d = ST_XFER;
                    beat_d  = '0;
                end
            end
            ST_XFER: begin
                if (m_hs) begin
                    if (src_tlast) begin
                        state_d   = ST_END;
                        rr_last_d = grant;
                        gap_d     = '0;
                    end else if (last_slot) begin
                        state_d = ST_DROP;
                        trunc_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (drop_hs && src_tlast) begin
                    state_d   = ST_END;
                    rr_last_d = grant;
                    gap_d     = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register FSM state plus the registered busy and truncation pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            gap_q     <= '0;
            rr_last_q <= SRC1;
            trunc_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            rr_last_q <= rr_last_d;
            trunc_q   <= trunc_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign busy      = busy_q;
    assign trunc_err = trunc_q;

endmodule
